// File: rtl/pipe_memory_stage_if.sv
// M-stage bus: pipeline inputs from the M register, forwarding outputs,
// and the registered W outputs consumed by write-back.
interface pipe_memory_stage_if #(
    parameter int WORD_BYTES = 8,
    parameter int ADDR_W     = 64
);
    localparam int DATA_W = 8 * WORD_BYTES;

    logic [2:0]        M_stat;
    logic [3:0]        M_icode;
    logic [ADDR_W-1:0] M_valE;
    logic [DATA_W-1:0] M_valA;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic              W_stall;
    logic              W_bubble;

    logic [DATA_W-1:0] m_valM;
    logic [2:0]        m_stat;
    logic [2:0]        W_stat;
    logic [3:0]        W_icode;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;

    // Pipeline control / M-register side
    modport master (
        output M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
        input  m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );

    // Memory stage itself
    modport slave (
        input  M_stat, M_icode, M_valE, M_valA, M_dstE, M_dstM, W_stall, W_bubble,
        output m_valM, m_stat, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
    );
endinterface

// File: rtl/pipe_memory_stage.sv
// Y86-64 pipelined memory stage: byte-addressed little-endian data memory
// with range checking, exception-aware write suppression and the W register.
module pipe_memory_stage #(
    parameter int WORD_BYTES = 8,
    parameter int MEM_BYTES  = 1024,
    parameter int ADDR_W     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_memory_stage_if.slave   io_bus
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int IDX_W  = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    // Highest start address whose whole word still lies inside the array
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - WORD_BYTES);

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    logic [7:0]        r_mem [MEM_BYTES];

    logic              w_rd;
    logic              w_wr;
    logic              w_err;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_addr;
    logic [IDX_W-1:0]  w_base;
    logic [DATA_W-1:0] w_valM;
    logic [2:0]        w_stat;

    logic [2:0]        r_W_stat;
    logic [3:0]        r_W_icode;
    logic [DATA_W-1:0] r_W_valE;
    logic [DATA_W-1:0] r_W_valM;
    logic [3:0]        r_W_dstE;
    logic [3:0]        r_W_dstM;

    // Access decode, address select and full-width range check (no wrap)
    always_comb begin
        w_rd   = (io_bus.M_icode == I_MRMOVQ) || (io_bus.M_icode == I_RET) ||
                 (io_bus.M_icode == I_POPQ);
        w_wr   = (io_bus.M_icode == I_RMMOVQ) || (io_bus.M_icode == I_CALL) ||
                 (io_bus.M_icode == I_PUSHQ);
        w_addr = ((io_bus.M_icode == I_RET) || (io_bus.M_icode == I_POPQ)) ?
                 ADDR_W'(io_bus.M_valA) : io_bus.M_valE;
        w_err  = (w_rd || w_wr) && (w_addr > LAST_OK);
        // Only meaningful when w_err is low, so truncation is safe
        w_base = w_addr[IDX_W-1:0];
        w_stat = w_err ? S_ADR : io_bus.M_stat;
        // An older exception in W or this one's own bad status kills the store
        w_wr_en = w_wr && !w_err && (io_bus.M_stat == S_AOK) &&
                  (r_W_stat == S_AOK) && !reset;
    end

    // Combinational little-endian read of the current array contents
    always_comb begin
        w_valM = '0;
        if (w_rd && !w_err) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                w_valM[8*i +: 8] = r_mem[w_base + IDX_W'(i)];
            end
        end
    end

    // Store commit; array is deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                r_mem[w_base + IDX_W'(i)] <= io_bus.M_valA[8*i +: 8];
            end
        end
    end

    // W pipeline register: reset > stall > bubble > load
    always_ff @(posedge clk) begin
        if (reset || (!io_bus.W_stall && io_bus.W_bubble)) begin
            r_W_stat  <= S_AOK;
            r_W_icode <= I_NOP;
            r_W_valE  <= '0;
            r_W_valM  <= '0;
            r_W_dstE  <= R_NONE;
            r_W_dstM  <= R_NONE;
        end else if (!io_bus.W_stall) begin
            r_W_stat  <= w_stat;
            r_W_icode <= io_bus.M_icode;
            r_W_valE  <= DATA_W'(io_bus.M_valE);
            r_W_valM  <= w_valM;
            r_W_dstE  <= io_bus.M_dstE;
            r_W_dstM  <= io_bus.M_dstM;
        end
    end

    assign io_bus.m_valM  = w_valM;
    assign io_bus.m_stat  = w_stat;
    assign io_bus.W_stat  = r_W_stat;
    assign io_bus.W_icode = r_W_icode;
    assign io_bus.W_valE  = r_W_valE;
    assign io_bus.W_valM  = r_W_valM;
    assign io_bus.W_dstE  = r_W_dstE;
    assign io_bus.W_dstM  = r_W_dstM;
endmodule

// File: tb/tb_pipe_memory_stage.sv
// Bench for pipe_memory_stage: byte-level reference model plus directed
// vectors with literal expectations.
module tb_pipe_memory_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   run     = 1'b0;

    pipe_memory_stage_if #(.WORD_BYTES(8), .ADDR_W(64)) bus ();

    pipe_memory_stage #(.WORD_BYTES(8), .MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit [7:0] mm [longint unsigned];   // only bytes ever stored
    logic [2:0]  e_stat;
    logic [3:0]  e_icode, e_dstE, e_dstM;
    logic [63:0] e_valE, e_valM;
    bit          e_valM_k = 1'b0;

    function automatic bit is_rd(input logic [3:0] ic);
        return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
    endfunction
    function automatic bit is_wr(input logic [3:0] ic);
        return ic == 4'h4 || ic == 4'h8 || ic == 4'hA;
    endfunction
    function automatic longint unsigned ea();
        return (bus.M_icode == 4'h9 || bus.M_icode == 4'hB) ? bus.M_valA : bus.M_valE;
    endfunction
    function automatic bit bad();
        longint unsigned a = ea();
        return (is_rd(bus.M_icode) || is_wr(bus.M_icode)) && (a > 64'd1016);
    endfunction

    // Expected m_valM / m_stat from current inputs and model memory
    task automatic comb_exp(output logic [63:0] v, output bit k, output logic [2:0] st);
        longint unsigned a = ea();
        v  = 64'd0;
        k  = 1'b1;
        st = bad() ? 3'd3 : bus.M_stat;
        if (is_rd(bus.M_icode) && !bad()) begin
            for (int i = 0; i < 8; i++) begin
                if (mm.exists(a + longint'(i))) v[8*i +: 8] = mm[a + longint'(i)];
                else k = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        logic [63:0] v;
        bit k;
        logic [2:0] st;
        longint unsigned a;
        comb_exp(v, k, st);
        a = ea();
        if (!reset && is_wr(bus.M_icode) && !bad() && bus.M_stat == 3'd1 && e_stat == 3'd1)
            for (int i = 0; i < 8; i++) mm[a + longint'(i)] = bus.M_valA[8*i +: 8];
        if (reset || (!bus.W_stall && bus.W_bubble)) begin
            e_stat = 3'd1; e_icode = 4'h1; e_valE = 64'd0; e_valM = 64'd0;
            e_valM_k = 1'b1; e_dstE = 4'hF; e_dstM = 4'hF;
        end else if (!bus.W_stall) begin
            e_stat = st; e_icode = bus.M_icode; e_valE = bus.M_valE; e_valM = v;
            e_valM_k = k; e_dstE = bus.M_dstE; e_dstM = bus.M_dstM;
        end
    end

    // Compare DUT against model every cycle, away from the active edge
    always @(negedge clk) begin
        logic [63:0] v;
        bit k;
        logic [2:0] st;
        if (run) begin
            comb_exp(v, k, st);
            chk("m_stat", bus.m_stat, st);
            if (k) chk("m_valM", bus.m_valM, v);
            chk("W_stat",  bus.W_stat,  e_stat);
            chk("W_icode", bus.W_icode, e_icode);
            chk("W_valE",  bus.W_valE,  e_valE);
            chk("W_dstE",  bus.W_dstE,  e_dstE);
            chk("W_dstM",  bus.W_dstM,  e_dstM);
            if (e_valM_k) chk("W_valM", bus.W_valM, e_valM);
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                      input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
        reset = 1'b0; bus.W_stall = 1'b0; bus.W_bubble = 1'b0;
        bus.M_stat = st; bus.M_icode = ic; bus.M_valE = ve; bus.M_valA = va;
        bus.M_dstE = de; bus.M_dstM = dm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.W_stall = 1'b0; bus.W_bubble = 1'b0;
        bus.M_stat = 3'd1; bus.M_icode = 4'h1; bus.M_valE = '0; bus.M_valA = '0;
        bus.M_dstE = 4'hF; bus.M_dstM = 4'hF;
        tick();
        run = 1'b1;
        tick();
        chk("rst_W_icode", bus.W_icode, 64'h1);
        chk("rst_W_dstE", bus.W_dstE, 64'hF);
        chk("rst_W_dstM", bus.W_dstM, 64'hF);
        chk("rst_W_stat", bus.W_stat, 64'h1);
        chk("rst_W_valM", bus.W_valM, 64'h0);

        // store then load
        op(3'd1, 4'h4, 64'd16, 64'h1122334455667788, 4'hF, 4'hF); tick();
        op(3'd1, 4'h5, 64'd16, 64'd0, 4'hF, 4'd3);
        chk("ld16_m_valM", bus.m_valM, 64'h1122334455667788);
        tick();
        chk("ld16_W_valM", bus.W_valM, 64'h1122334455667788);
        chk("ld16_W_stat", bus.W_stat, 64'h1);

        // byte order, misaligned read
        op(3'd1, 4'h4, 64'd108, 64'd0, 4'hF, 4'hF); tick();
        op(3'd1, 4'hA, 64'd100, 64'h0807060504030201, 4'd4, 4'hF); tick();
        op(3'd1, 4'h5, 64'd101, 64'd0, 4'hF, 4'd1);
        chk("le101", bus.m_valM, 64'h0008070605040302);
        tick();

        // boundaries and suppression
        op(3'd1, 4'h4, 64'd1016, 64'hDEADBEEFCAFEF00D, 4'hF, 4'hF); tick();
        op(3'd1, 4'h4, 64'd40, 64'd5, 4'hF, 4'hF); tick();
        op(3'd1, 4'h5, 64'd1016, 64'd0, 4'hF, 4'd2);
        chk("b1016_stat", bus.m_stat, 64'h1);
        tick();
        op(3'd1, 4'h5, 64'd1017, 64'd0, 4'hF, 4'd2);
        chk("b1017_stat", bus.m_stat, 64'h3);
        chk("b1017_valM", bus.m_valM, 64'h0);
        tick();
        chk("b1017_W_stat", bus.W_stat, 64'h3);
        op(3'd1, 4'h4, 64'd40, 64'd69, 4'hF, 4'hF); tick();
        op(3'd1, 4'h5, 64'd40, 64'd0, 4'hF, 4'd2);
        chk("supp_W_adr", bus.m_valM, 64'd5);
        tick();
        op(3'd1, 4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'hAAAA_AAAA_AAAA_AAAA, 4'hF, 4'hF);
        chk("wrap_stat", bus.m_stat, 64'h3);
        tick();
        op(3'd1, 4'h5, 64'd1016, 64'd0, 4'hF, 4'd2);
        chk("wrap_reread", bus.m_valM, 64'hDEADBEEFCAFEF00D);
        tick();

        // call / ret / popq
        op(3'd1, 4'h8, 64'd200, 64'd420, 4'd4, 4'hF); tick();
        op(3'd1, 4'h9, 64'd208, 64'd200, 4'd4, 4'hF);
        chk("ret_valM", bus.m_valM, 64'd420);
        tick();
        op(3'd1, 4'hB, 64'd208, 64'd200, 4'd4, 4'd5);
        chk("pop_valM", bus.m_valM, 64'd420);
        tick();

        // bad own status blocks the store
        op(3'd4, 4'h4, 64'd40, 64'd77, 4'hF, 4'hF); tick();
        op(3'd1, 4'h5, 64'd40, 64'd0, 4'hF, 4'd2);
        chk("supp_ins", bus.m_valM, 64'd5);
        tick();

        // stall / bubble control
        op(3'd1, 4'h5, 64'd16, 64'd0, 4'd2, 4'd7); tick();
        op(3'd1, 4'h6, 64'd999, 64'd0, 4'd3, 4'd3);
        bus.W_stall = 1'b1;
        tick(); tick();
        chk("stall_dstM", bus.W_dstM, 64'd7);
        chk("stall_valM", bus.W_valM, 64'h1122334455667788);
        chk("stall_valE", bus.W_valE, 64'd16);
        bus.W_bubble = 1'b1;
        tick();
        chk("stbub_dstM", bus.W_dstM, 64'd7);
        bus.W_stall = 1'b0;
        tick();
        chk("bub_icode", bus.W_icode, 64'h1);
        chk("bub_dstM", bus.W_dstM, 64'hF);
        chk("bub_valM", bus.W_valM, 64'h0);

        // reset alongside a valid store
        op(3'd1, 4'h4, 64'd48, 64'h1111, 4'hF, 4'hF); tick();
        op(3'd1, 4'h4, 64'd48, 64'h2222, 4'hF, 4'hF);
        reset = 1'b1;
        tick();
        chk("rstw_icode", bus.W_icode, 64'h1);
        chk("rstw_dstE", bus.W_dstE, 64'hF);
        chk("rstw_valE", bus.W_valE, 64'h0);
        op(3'd1, 4'h5, 64'd48, 64'd0, 4'hF, 4'd2);
        chk("rstw_read", bus.m_valM, 64'h1111);
        tick();
        op(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);
        tick(); tick();

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
